// File: rtl/fft_ram_pkg.sv
// rtl/fft_ram_pkg.sv - shared types and constants for the FFT ping-pong RAM
// Contents: FSM state enum, legal read-latency values, bank-index type.
package fft_ram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    // Legal read latencies: data from the array register, or one extra output stage.
    localparam int RD_LAT_REG  = 1;
    localparam int RD_LAT_PIPE = 2;

    typedef logic bank_idx_t;

endpackage

// File: rtl/fft_ram_bank.sv
// rtl/fft_ram_bank.sv - single-port synchronous RAM bank with RD_LAT output stage
// Ports: clk, rst (async, active-high; resets output registers only),
//        en/we/addr/din access, dout read data RD_LAT cycles after a read.
module fft_ram_bank
    import fft_ram_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = RD_LAT_REG
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_q, rd_d;

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= din;
        end
    end

    // Read register holds its value between reads.
    always_comb begin
        rd_d = rd_q;
        if (en && !we) begin
            rd_d = mem[addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

    generate
        if (RD_LAT == RD_LAT_PIPE) begin : g_out_reg
            logic [WIDTH-1:0] out_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_q <= '0;
                end else begin
                    out_q <= rd_q;
                end
            end
            assign dout = out_q;
        end else begin : g_no_out_reg
            assign dout = rd_q;
        end
    endgenerate

endmodule

// File: rtl/fft_pingpong_ram.sv
// rtl/fft_pingpong_ram.sv - two-bank ping-pong RAM with handshaked swap and optional clear sweep
// Ports: port A (a_*) accesses the active bank, port B (b_*) the inactive one;
//        swap_req/swap_ack exchange banks, bank_sel is the active bank index;
//        clr_req/clr_busy zero both banks when FFT_RAM_CLEAR_EN is defined.
module fft_pingpong_ram
    import fft_ram_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = RD_LAT_REG
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     a_en,
    input  logic                     a_we,
    input  logic [$clog2(DEPTH)-1:0] a_addr,
    input  logic [WIDTH-1:0]         a_din,
    output logic                     a_rdy,
    output logic [WIDTH-1:0]         a_dout,
    output logic                     a_vld,
    input  logic                     b_en,
    input  logic                     b_we,
    input  logic [$clog2(DEPTH)-1:0] b_addr,
    input  logic [WIDTH-1:0]         b_din,
    output logic                     b_rdy,
    output logic [WIDTH-1:0]         b_dout,
    output logic                     b_vld,
    input  logic                     swap_req,
    output logic                     swap_ack,
    output logic                     bank_sel,
    input  logic                     clr_req,
    output logic                     clr_busy
);

    localparam int AW = $clog2(DEPTH);

    state_t            state_q, state_d;
    bank_idx_t         bank_sel_q, bank_sel_d;
    logic              swap_ack_q, swap_ack_d;
    logic              rdy_q, rdy_d;
    logic              clr_busy_q, clr_busy_d;
    logic [RD_LAT-1:0] a_pipe_q, a_pipe_d;
    logic [RD_LAT-1:0] b_pipe_q, b_pipe_d;

    logic              a_acc, b_acc, a_rd, b_rd;
    logic              reads_busy, swap_go;
    logic              clr_act;
    logic [AW-1:0]     clr_addr;

`ifdef FFT_RAM_CLEAR_EN
    logic          clr_pend_q, clr_pend_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
    assign clr_act  = (state_q == ST_CLEAR);
    assign clr_addr = clr_cnt_q;
`else
    logic unused_clr_req;
    assign unused_clr_req = clr_req;
    assign clr_act        = 1'b0;
    assign clr_addr       = '0;
`endif

    assign a_acc = a_en && rdy_q;
    assign b_acc = b_en && rdy_q;
    assign a_rd  = a_acc && !a_we;
    assign b_rd  = b_acc && !b_we;

    // A read is in flight until the cycle its valid is presented; the final
    // pipe stage is the valid itself and does not block a swap.
    always_comb begin
        reads_busy = a_rd || b_rd;
        for (int i = 0; i < RD_LAT - 1; i++) begin
            reads_busy = reads_busy || a_pipe_q[i] || b_pipe_q[i];
        end
    end

    always_comb begin
        a_pipe_d    = '0;
        b_pipe_d    = '0;
        a_pipe_d[0] = a_rd;
        b_pipe_d[0] = b_rd;
        for (int i = 1; i < RD_LAT; i++) begin
            a_pipe_d[i] = a_pipe_q[i-1];
            b_pipe_d[i] = b_pipe_q[i-1];
        end
    end

    // swap_req is a level held until ack; masking it during the ack cycle
    // prevents the still-high request from triggering a second swap.
    assign swap_go = swap_req && !swap_ack_q;

    always_comb begin
        state_d    = state_q;
        bank_sel_d = bank_sel_q;
        swap_ack_d = 1'b0;
`ifdef FFT_RAM_CLEAR_EN
        clr_pend_d = clr_pend_q;
        clr_cnt_d  = clr_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef FFT_RAM_CLEAR_EN
                if (clr_req || clr_pend_q) begin
                    state_d    = ST_CLEAR;
                    clr_pend_d = 1'b0;
                    clr_cnt_d  = '0;
                end else
`endif
                if (swap_go) begin
                    if (reads_busy) begin
                        state_d = ST_DRAIN;
                    end else begin
                        bank_sel_d = ~bank_sel_q;
                        swap_ack_d = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
`ifdef FFT_RAM_CLEAR_EN
                if (clr_req) begin
                    clr_pend_d = 1'b1;
                end
`endif
                if (!reads_busy) begin
                    state_d    = ST_IDLE;
                    bank_sel_d = ~bank_sel_q;
                    swap_ack_d = 1'b1;
                end
            end
`ifdef FFT_RAM_CLEAR_EN
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == AW'(DEPTH - 1)) begin
                    state_d   = ST_IDLE;
                    clr_cnt_d = '0;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
        rdy_d      = (state_d == ST_IDLE);
        clr_busy_d = (state_d == ST_CLEAR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bank_sel_q <= 1'b0;
            swap_ack_q <= 1'b0;
            rdy_q      <= 1'b1;
            clr_busy_q <= 1'b0;
            a_pipe_q   <= '0;
            b_pipe_q   <= '0;
`ifdef FFT_RAM_CLEAR_EN
            clr_pend_q <= 1'b0;
            clr_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            bank_sel_q <= bank_sel_d;
            swap_ack_q <= swap_ack_d;
            rdy_q      <= rdy_d;
            clr_busy_q <= clr_busy_d;
            a_pipe_q   <= a_pipe_d;
            b_pipe_q   <= b_pipe_d;
`ifdef FFT_RAM_CLEAR_EN
            clr_pend_q <= clr_pend_d;
            clr_cnt_q  <= clr_cnt_d;
`endif
        end
    end

    // Bank k belongs to port A when bank_sel == k, otherwise to port B;
    // the clear writer overrides both while sweeping.
    logic             bk_en   [2];
    logic             bk_we   [2];
    logic [AW-1:0]    bk_addr [2];
    logic [WIDTH-1:0] bk_din  [2];
    logic [WIDTH-1:0] bk_dout [2];

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            if (clr_act) begin
                bk_en[k]   = 1'b1;
                bk_we[k]   = 1'b1;
                bk_addr[k] = clr_addr;
                bk_din[k]  = '0;
            end else if (bank_sel_q == bank_idx_t'(k)) begin
                bk_en[k]   = a_acc;
                bk_we[k]   = a_we;
                bk_addr[k] = a_addr;
                bk_din[k]  = a_din;
            end else begin
                bk_en[k]   = b_acc;
                bk_we[k]   = b_we;
                bk_addr[k] = b_addr;
                bk_din[k]  = b_din;
            end
        end
    end

    fft_ram_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) u_bank0 (
        .clk  (clk),
        .rst  (rst),
        .en   (bk_en[0]),
        .we   (bk_we[0]),
        .addr (bk_addr[0]),
        .din  (bk_din[0]),
        .dout (bk_dout[0])
    );

    fft_ram_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) u_bank1 (
        .clk  (clk),
        .rst  (rst),
        .en   (bk_en[1]),
        .we   (bk_we[1]),
        .addr (bk_addr[1]),
        .din  (bk_din[1]),
        .dout (bk_dout[1])
    );

    // Drain guarantees bank_sel is stable while any read result is pending.
    assign a_dout   = bank_sel_q ? bk_dout[1] : bk_dout[0];
    assign b_dout   = bank_sel_q ? bk_dout[0] : bk_dout[1];
    assign a_vld    = a_pipe_q[RD_LAT-1];
    assign b_vld    = b_pipe_q[RD_LAT-1];
    assign a_rdy    = rdy_q;
    assign b_rdy    = rdy_q;
    assign swap_ack = swap_ack_q;
    assign bank_sel = bank_sel_q;
    assign clr_busy = clr_busy_q;

endmodule

// File: tb/tb_fft_pingpong_ram.sv
// tb/tb_fft_pingpong_ram.sv - self-checking bench for fft_pingpong_ram (clear tests under FFT_RAM_CLEAR_EN)
module tb_fft_pingpong_ram;

    localparam int WIDTH  = 16;
    localparam int DEPTH  = 16;
    localparam int RD_LAT = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              a_en, a_we, b_en, b_we;
    logic [3:0]        a_addr, b_addr;
    logic [WIDTH-1:0]  a_din, b_din;
    logic              a_rdy, a_vld, b_rdy, b_vld;
    logic [WIDTH-1:0]  a_dout, b_dout;
    logic              swap_req, swap_ack, bank_sel, clr_req, clr_busy;

    fft_pingpong_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
        .a_rdy(a_rdy), .a_dout(a_dout), .a_vld(a_vld),
        .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
        .b_rdy(b_rdy), .b_dout(b_dout), .b_vld(b_vld),
        .swap_req(swap_req), .swap_ack(swap_ack), .bank_sel(bank_sel),
        .clr_req(clr_req), .clr_busy(clr_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] d;
        int               c;
    } exp_t;

    exp_t             a_q[$];
    exp_t             b_q[$];
    logic [WIDTH-1:0] model [2][DEPTH];
    int               msel = 0;
    int               checks = 0;
    int               errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: read results popped and checked for data and arrival cycle.
    always @(negedge clk) begin
        if (!rst && a_vld) begin
            checks++;
            assert (a_q.size() > 0) else begin
                errors++;
                $error("FAIL a_vld_unexpected observed=1 expected=0");
            end
            if (a_q.size() > 0) begin
                exp_t e;
                e = a_q.pop_front();
                checks++;
                assert (a_dout === e.d) else begin
                    errors++;
                    $error("FAIL a_dout observed=%0h expected=%0h", a_dout, e.d);
                end
                checks++;
                assert (cyc == e.c) else begin
                    errors++;
                    $error("FAIL a_vld_cycle observed=%0d expected=%0d", cyc, e.c);
                end
            end
        end
        if (!rst && b_vld) begin
            checks++;
            assert (b_q.size() > 0) else begin
                errors++;
                $error("FAIL b_vld_unexpected observed=1 expected=0");
            end
            if (b_q.size() > 0) begin
                exp_t e;
                e = b_q.pop_front();
                checks++;
                assert (b_dout === e.d) else begin
                    errors++;
                    $error("FAIL b_dout observed=%0h expected=%0h", b_dout, e.d);
                end
                checks++;
                assert (cyc == e.c) else begin
                    errors++;
                    $error("FAIL b_vld_cycle observed=%0d expected=%0d", cyc, e.c);
                end
            end
        end
    end

    task automatic wait_rdy();
        int n = 0;
        while (!(a_rdy && b_rdy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rdy_timeout", {31'd0, a_rdy && b_rdy}, 32'd1);
    endtask

    task automatic a_op(input logic we, input logic [3:0] addr, input logic [WIDTH-1:0] din);
        a_en = 1'b1; a_we = we; a_addr = addr; a_din = din;
        wait_rdy();
        if (we) model[msel][addr] = din;
        else    a_q.push_back('{model[msel][addr], cyc + RD_LAT});
        @(negedge clk);
        a_en = 1'b0; a_we = 1'b0;
    endtask

    task automatic b_op(input logic we, input logic [3:0] addr, input logic [WIDTH-1:0] din);
        b_en = 1'b1; b_we = we; b_addr = addr; b_din = din;
        wait_rdy();
        if (we) model[msel ^ 1][addr] = din;
        else    b_q.push_back('{model[msel ^ 1][addr], cyc + RD_LAT});
        @(negedge clk);
        b_en = 1'b0; b_we = 1'b0;
    endtask

    // Wait for swap_ack; lat < 0 skips the latency check.
    task automatic wait_ack(input int n0, input int lat, input string tag);
        int n = 0;
        int old_sel;
        old_sel = msel;
        while (!swap_ack && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ack_seen"}, {31'd0, swap_ack}, 32'd1);
        if (lat >= 0) chk({tag, "_ack_lat"}, cyc - n0, lat);
        msel = old_sel ^ 1;
        chk({tag, "_bank_sel"}, {31'd0, bank_sel}, msel);
        swap_req = 1'b0;
        @(negedge clk);
        chk({tag, "_ack_pulse"}, {31'd0, swap_ack}, 32'd0);
        chk({tag, "_sel_once"}, {31'd0, bank_sel}, msel);
    endtask

    task automatic do_swap(input int lat, input string tag);
        int n0;
        swap_req = 1'b1;
        n0 = cyc;
        @(negedge clk);
        wait_ack(n0, lat, tag);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_a_rdy"}, {31'd0, a_rdy}, 32'd1);
        chk({tag, "_b_rdy"}, {31'd0, b_rdy}, 32'd1);
        chk({tag, "_a_vld"}, {31'd0, a_vld}, 32'd0);
        chk({tag, "_b_vld"}, {31'd0, b_vld}, 32'd0);
        chk({tag, "_a_dout"}, {16'd0, a_dout}, 32'd0);
        chk({tag, "_b_dout"}, {16'd0, b_dout}, 32'd0);
        chk({tag, "_swap_ack"}, {31'd0, swap_ack}, 32'd0);
        chk({tag, "_bank_sel"}, {31'd0, bank_sel}, 32'd0);
        chk({tag, "_clr_busy"}, {31'd0, clr_busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int n;
        rst = 1'b1;
        a_en = 0; a_we = 0; a_addr = 0; a_din = 0;
        b_en = 0; b_we = 0; b_addr = 0; b_din = 0;
        swap_req = 0; clr_req = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("reset");

        // Fill both banks with known contents.
        for (int i = 0; i < DEPTH; i++) begin
            a_op(1'b1, 4'(i), 16'h1000 + 16'(i));
            b_op(1'b1, 4'(i), 16'h2000 + 16'(i));
        end

        // Write on B, immediate swap, read back on A.
        b_op(1'b1, 4'd5, 16'h0011);
        do_swap(1, "swap_idle");
        a_op(1'b0, 4'd5, '0);
        b_op(1'b0, 4'd5, '0);

        // Two back-to-back A reads, swap requested the next cycle.
        a_en = 1'b1; a_we = 1'b0; a_addr = 4'd1;
        a_q.push_back('{model[msel][1], cyc + RD_LAT});
        @(negedge clk);
        a_addr = 4'd2;
        a_q.push_back('{model[msel][2], cyc + RD_LAT});
        @(negedge clk);
        a_en = 1'b0;
        swap_req = 1'b1;
        n0 = cyc;
        @(negedge clk);
        chk("drain_a_rdy", {31'd0, a_rdy}, 32'd0);
        chk("drain_b_rdy", {31'd0, b_rdy}, 32'd0);
        wait_ack(n0, RD_LAT, "swap_drain");

        // Read presented in the same cycle as swap_req is accepted, then drained.
        a_en = 1'b1; a_we = 1'b0; a_addr = 4'd3;
        a_q.push_back('{model[msel][3], cyc + RD_LAT});
        swap_req = 1'b1;
        n0 = cyc;
        @(negedge clk);
        a_en = 1'b0;
        wait_ack(n0, RD_LAT + 1, "swap_same");

        // A write and B read of the same address in the same cycle.
        a_en = 1'b1; a_we = 1'b1; a_addr = 4'd0; a_din = 16'hABCD;
        b_en = 1'b1; b_we = 1'b0; b_addr = 4'd0;
        b_q.push_back('{model[msel ^ 1][0], cyc + RD_LAT});
        model[msel][0] = 16'hABCD;
        @(negedge clk);
        a_en = 1'b0; a_we = 1'b0; b_en = 1'b0;
        a_op(1'b0, 4'd0, '0);
        b_op(1'b0, 4'd0, '0);

        // Mixed traffic with occasional swaps.
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0: a_op(1'b1, 4'($urandom_range(0, DEPTH - 1)), 16'($urandom));
                1: a_op(1'b0, 4'($urandom_range(0, DEPTH - 1)), '0);
                2: b_op(1'b1, 4'($urandom_range(0, DEPTH - 1)), 16'($urandom));
                default: b_op(1'b0, 4'($urandom_range(0, DEPTH - 1)), '0);
            endcase
            if (i % 8 == 7) do_swap(-1, "swap_mix");
        end
        repeat (4) @(negedge clk);

`ifdef FFT_RAM_CLEAR_EN
        // Clear sweep: busy for exactly DEPTH cycles, then all zero.
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        n = 0;
        while (clr_busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("clr_busy_len", n, DEPTH);
        chk("clr_rdy_after", {31'd0, a_rdy}, 32'd1);
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < DEPTH; i++) model[k][i] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            a_op(1'b0, 4'(i), '0);
            b_op(1'b0, 4'(i), '0);
        end
        a_op(1'b1, 4'd7, 16'h5555);
        repeat (4) @(negedge clk);

        // Clear and swap in the same cycle: clear first, swap right after.
        clr_req = 1'b1;
        swap_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        chk("clr_swap_busy", {31'd0, clr_busy}, 32'd1);
        n = 0;
        while (clr_busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("clr_swap_len", n, DEPTH);
        chk("clr_swap_no_early_ack", {31'd0, swap_ack}, 32'd0);
        model[msel][7] = '0;
        wait_ack(cyc, 1, "clr_swap");
        a_op(1'b0, 4'd7, '0);
        b_op(1'b0, 4'd7, '0);
        repeat (4) @(negedge clk);

        // Reset in the third cycle of a clear.
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("clr_mid_busy", {31'd0, clr_busy}, 32'd1);
`else
        if (bank_sel == 1'b0) do_swap(-1, "pre_rst");
        chk("pre_rst_sel", {31'd0, bank_sel}, 32'd1);
`endif
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("mid_rst");
        rst = 1'b0;
        msel = 0;
        @(negedge clk);
        chk("post_rst_a_rdy", {31'd0, a_rdy}, 32'd1);
        chk("post_rst_sel", {31'd0, bank_sel}, 32'd0);
        chk("post_rst_busy", {31'd0, clr_busy}, 32'd0);
        a_op(1'b1, 4'd9, 16'h0F0F);
        b_op(1'b1, 4'd9, 16'h7070);
        a_op(1'b0, 4'd9, '0);
        b_op(1'b0, 4'd9, '0);

        repeat (6) @(negedge clk);
        chk("a_q_empty", a_q.size(), 32'd0);
        chk("b_q_empty", b_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
